// File: rtl/stream_rr_arbiter.sv
// Three-way round-robin arbiter onto one valid/ready stream; bursts of up to MAX_BURST beats per grant.
// One re-arbitration cycle between grants, one-entry tagged output register; upstream ready follows output-register space.
module stream_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid_i,
    input  logic [3*DATA_W-1:0] req_data_i,
    output logic [2:0]          req_ready_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [1:0]          out_id_o,
    output logic [2:0]          grant_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [1:0]         rr_ptr;
    logic [1:0]         g_idx;
    logic [CNT_W-1:0]   beat_cnt;

    logic               load_en;
    logic               sel_valid;
    logic               xfer;
    logic               last_beat;
    logic [DATA_W-1:0]  sel_data;
    logic [1:0]         cand0, cand1, cand2;
    logic [1:0]         pick_idx;

    function automatic logic [1:0] next_idx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Scan order starts at rr_ptr and wraps modulo 3.
    always_comb begin
        cand0 = rr_ptr;
        cand1 = next_idx(cand0);
        cand2 = next_idx(cand1);
        pick_idx = cand2;
        if (req_valid_i[cand0])
            pick_idx = cand0;
        else if (req_valid_i[cand1])
            pick_idx = cand1;
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (grant_o[k])
                sel_data = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    assign sel_valid   = |(req_valid_i & grant_o);
    assign load_en     = !out_valid_o || out_ready_i;
    assign xfer        = (state == GRANT) && sel_valid && load_en;
    assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign req_ready_o = ((state == GRANT) && load_en) ? grant_o : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            g_idx       <= 2'd0;
            beat_cnt    <= '0;
            grant_o     <= 3'b000;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= 2'd0;
        end else begin
            // Output register drains on its own, whatever the arbitration state.
            if (xfer) begin
                out_data_o  <= sel_data;
                out_id_o    <= g_idx;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        g_idx    <= pick_idx;
                        grant_o  <= 3'b001 << pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer)
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    if (!sel_valid || (xfer && last_beat)) begin
                        state   <= IDLE;
                        grant_o <= 3'b000;
                        rr_ptr  <= next_idx(g_idx);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
